// File: rtl/fir_mac_seq_if.sv
// Sample/coefficient/result bundle between the FIR tap memories, the MAC
// sequencer (slave) and whatever supplies strobes and memory data (master).
`timescale 1ns/1ps
interface fir_mac_seq_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 6
);
  logic                     sample_strobe;
  logic signed [DATA_W-1:0] imem_data;
  logic signed [DATA_W-1:0] coef_data;
  logic [ADDR_W-1:0]        read_addr;
  logic                     busy;
  logic signed [DATA_W-1:0] y_out;
  logic                     y_valid;
  logic                     sample_overrun;

  modport master (
    output sample_strobe, imem_data, coef_data,
    input  read_addr, busy, y_out, y_valid, sample_overrun
  );

  modport slave (
    input  sample_strobe, imem_data, coef_data,
    output read_addr, busy, y_out, y_valid, sample_overrun
  );
endinterface

// File: rtl/fir_mac_seq.sv
// FIR tap sequencer + MAC: one sweep of all taps per sample strobe, one output sample.
// Define FIR_MAC_SAT_EN to saturate the output instead of wrapping it.
`timescale 1ns/1ps
module fir_mac_seq #(
  parameter int DATA_W    = 16,
  parameter int TAPS      = 64,
  parameter int ACC_W     = 38,
  parameter int OUT_SHIFT = 15
) (
  input  logic          clk,
  input  logic          reset,
  fir_mac_seq_if.slave  bus
);
  localparam int AW     = $clog2(TAPS);
  localparam int PROD_W = 2 * DATA_W;
  localparam int S_W    = ACC_W - OUT_SHIFT;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t                    r_state, w_state_nxt;
  logic [AW-1:0]             r_addr, w_addr_nxt;
  logic                      r_drain, w_drain_nxt;
  logic                      r_busy, w_busy_nxt;
  logic                      r_dv, r_pv;
  logic signed [PROD_W-1:0]  r_prod;
  logic signed [ACC_W-1:0]   r_acc;
  logic signed [DATA_W-1:0]  r_y;
  logic                      r_y_valid;
  logic                      r_overrun;
  logic                      w_start;
  logic signed [S_W-1:0]     w_s;
  logic signed [DATA_W-1:0]  w_y;

  assign w_start = (r_state == S_IDLE) && bus.sample_strobe;

  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    w_drain_nxt = r_drain;
    case (r_state)
      S_IDLE: begin
        w_addr_nxt = '0;
        if (bus.sample_strobe) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (r_addr == AW'(TAPS - 1)) begin
          w_state_nxt = S_DRAIN;
          w_addr_nxt  = '0;
          w_drain_nxt = 1'b0;
        end else begin
          w_addr_nxt = r_addr + AW'(1);
        end
      end
      S_DRAIN: begin
        w_addr_nxt = '0;
        if (r_drain) w_state_nxt = S_DONE;
        else         w_drain_nxt = 1'b1;
      end
      S_DONE: begin
        w_addr_nxt  = '0;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    // Busy covers the result cycle: the first IDLE cycle after DONE still reports busy.
    w_busy_nxt = (w_state_nxt != S_IDLE) || (r_state == S_DONE);
  end

  assign w_s = S_W'(r_acc >>> OUT_SHIFT);

`ifdef FIR_MAC_SAT_EN
  always_comb begin
    w_y = w_s[DATA_W-1:0];
    if (!((&w_s[S_W-1:DATA_W-1]) || !(|w_s[S_W-1:DATA_W-1])))
      w_y = w_s[S_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
  end
`else
  logic w_unused_s;
  assign w_unused_s = ^w_s[S_W-1:DATA_W];
  assign w_y        = w_s[DATA_W-1:0];
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_addr    <= '0;
      r_drain   <= 1'b0;
      r_busy    <= 1'b0;
      r_dv      <= 1'b0;
      r_pv      <= 1'b0;
      r_prod    <= '0;
      r_acc     <= '0;
      r_y       <= '0;
      r_y_valid <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_addr  <= w_addr_nxt;
      r_drain <= w_drain_nxt;
      r_busy  <= w_busy_nxt;
      // Memory data lags the address by one cycle, the product by one more.
      r_dv    <= (r_state == S_RUN);
      r_pv    <= r_dv;
      r_prod  <= bus.imem_data * bus.coef_data;
      if (w_start)
        r_acc <= '0;
      else if (r_pv)
        r_acc <= r_acc + {{(ACC_W-PROD_W){r_prod[PROD_W-1]}}, r_prod};
      if (r_state == S_DONE) begin
        r_y       <= w_y;
        r_y_valid <= 1'b1;
      end else begin
        r_y_valid <= 1'b0;
      end
      if (bus.sample_strobe && (r_state != S_IDLE))
        r_overrun <= 1'b1;
    end
  end

  assign bus.read_addr      = r_addr;
  assign bus.busy           = r_busy;
  assign bus.y_out          = r_y;
  assign bus.y_valid        = r_y_valid;
  assign bus.sample_overrun = r_overrun;
endmodule

// File: tb/tb_fir_mac_seq.sv
// Directed bench for fir_mac_seq: reset, DC/negative/ramp/overflow sweeps,
// overrun detection, back-to-back strobes and mid-run reset.
`timescale 1ns/1ps
module tb_fir_mac_seq;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fir_mac_seq_if #(.DATA_W(16), .ADDR_W(6)) bus ();

  fir_mac_seq #(.DATA_W(16), .TAPS(64), .ACC_W(38), .OUT_SHIFT(15)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic signed [15:0] taps  [64];
  logic signed [15:0] coefs [64];

  // Tap and coefficient memories: data for an address is valid the cycle after.
  always @(posedge clk) begin
    bus.imem_data <= taps[bus.read_addr];
    bus.coef_data <= coefs[bus.read_addr];
  end

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fill(input logic signed [15:0] t, input logic signed [15:0] c);
    for (int i = 0; i < 64; i++) begin
      taps[i]  = t;
      coefs[i] = c;
    end
  endtask

  task automatic fill_ramp(input logic signed [15:0] c);
    for (int i = 0; i < 64; i++) begin
      taps[i]  = 16'(i);
      coefs[i] = c;
    end
  endtask

  // Walks one complete run cycle by cycle. ovr_cyc: cycle in which an extra
  // strobe is driven (-1 none). chain_out: strobe in the result cycle so the
  // next run starts immediately; chained_in: this run was started that way.
  task automatic run(input string tag, input logic [15:0] exp_y, input int ovr_cyc,
                     input bit chain_out, input bit chained_in);
    int addr_err = 0;
    int busy_err = 0;
    int vcnt     = 0;
    int exp_addr;
    logic       v_at = 1'b0;
    logic [15:0] y_at = '0;
    if (!chained_in) begin
      @(negedge clk);
      bus.sample_strobe = 1'b1;
      @(negedge clk);
    end
    for (int k = 0; k < 68; k++) begin
      if (k > 0) @(negedge clk);
      bus.sample_strobe = (k == ovr_cyc) || (chain_out && k == 67);
      exp_addr = (k < 64) ? k : 0;
      if (bus.read_addr !== 6'(exp_addr)) addr_err++;
      if (bus.busy !== 1'b1) busy_err++;
      if (bus.y_valid === 1'b1) vcnt++;
      if (k == 67) begin
        v_at = bus.y_valid;
        y_at = bus.y_out;
      end
    end
    @(negedge clk);
    bus.sample_strobe = 1'b0;
    check({tag, "_addr_seq"}, addr_err, 0);
    check({tag, "_busy_run"}, busy_err, 0);
    check({tag, "_valid_cnt"}, vcnt, 1);
    check({tag, "_valid_e67"}, {31'h0, v_at}, 32'h1);
    check({tag, "_y_out"}, {16'h0, y_at}, {16'h0, exp_y});
    check({tag, "_busy_after"}, {31'h0, bus.busy}, {31'h0, chain_out});
    check({tag, "_valid_after"}, {31'h0, bus.y_valid}, 32'h0);
  endtask

  int bad;

  initial begin
    reset = 1'b0;
    bus.sample_strobe = 1'b0;
    fill(16'sd0, 16'sd0);

    // T1: strobes while held in reset
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bus.sample_strobe = i[0];
      if (bus.y_valid !== 1'b0 || bus.busy !== 1'b0 || bus.read_addr !== 6'd0) bad++;
    end
    bus.sample_strobe = 1'b0;
    check("t1_quiet", bad, 0);
    check("t1_y_out", {16'h0, bus.y_out}, 32'h0);
    check("t1_overrun", {31'h0, bus.sample_overrun}, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // T2: DC
    fill(16'sd100, 16'sh4000);
    run("t2_dc", 16'd3200, -1, 1'b0, 1'b0);
    check("t2_overrun", {31'h0, bus.sample_overrun}, 32'h0);

    // Back-to-back: strobe in the first IDLE cycle, second run uses a ramp with -0.5
    run("t7_b2b_a", 16'd3200, -1, 1'b1, 1'b0);
    fill_ramp(16'shC000);
    run("t7_b2b_ramp", 16'hFC10, -1, 1'b0, 1'b1);
    check("t7_overrun", {31'h0, bus.sample_overrun}, 32'h0);
    repeat (5) @(negedge clk);
    check("t7_y_held", {16'h0, bus.y_out}, 32'h0000FC10);

    // T3: negative taps
    fill(-16'sd100, 16'sh4000);
    run("t3_neg", 16'hF380, -1, 1'b0, 1'b0);

    // T4: overflow
    fill(16'sd32767, 16'sd32767);
`ifdef FIR_MAC_SAT_EN
    run("t4_ovf", 16'h7FFF, -1, 1'b0, 1'b0);
`else
    run("t4_ovf", 16'hFF80, -1, 1'b0, 1'b0);
`endif

    // T5: overrun 30 clocks into a run
    fill(16'sd100, 16'sh4000);
    run("t5_ovr", 16'd3200, 29, 1'b0, 1'b0);
    check("t5_overrun_set", {31'h0, bus.sample_overrun}, 32'h1);
    run("t5_next", 16'd3200, -1, 1'b0, 1'b0);
    check("t5_overrun_sticky", {31'h0, bus.sample_overrun}, 32'h1);

    // T6: reset in cycle 40 of a run
    @(negedge clk);
    bus.sample_strobe = 1'b1;
    @(negedge clk);
    bus.sample_strobe = 1'b0;
    repeat (40) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("t6_addr", {26'h0, bus.read_addr}, 32'h0);
    check("t6_busy", {31'h0, bus.busy}, 32'h0);
    check("t6_y_out", {16'h0, bus.y_out}, 32'h0);
    check("t6_overrun", {31'h0, bus.sample_overrun}, 32'h0);
    reset = 1'b1;
    bad = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (bus.y_valid !== 1'b0 || bus.busy !== 1'b0) bad++;
    end
    check("t6_no_valid", bad, 0);
    run("t6_rerun", 16'd3200, -1, 1'b0, 1'b0);
    check("t6_overrun_after", {31'h0, bus.sample_overrun}, 32'h0);

    // Strobe during the DONE cycle counts as overrun and does not start a run
    run("t8_done_ovr", 16'd3200, 66, 1'b0, 1'b0);
    check("t8_overrun", {31'h0, bus.sample_overrun}, 32'h1);
    repeat (3) @(negedge clk);
    check("t8_idle", {31'h0, bus.busy}, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
